// File: rtl/stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM state
// codes, byte-enable patterns and the access legality check.
package stage_pkg;

    typedef logic [1:0] state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // True when the request must be rejected without touching memory.
    function automatic logic access_illegal(input logic       rd_en,
                                            input logic       wr_en,
                                            input logic [2:0] f3,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (rd_en && wr_en) begin
            bad = 1'b1;
        end else if (rd_en) begin
            case (f3)
                F3_B, F3_BU: bad = 1'b0;
                F3_H, F3_HU: bad = addr_lo[0];
                F3_W:        bad = |addr_lo;
                default:     bad = 1'b1;
            endcase
        end else if (wr_en) begin
            case (f3)
                F3_B:    bad = 1'b0;
                F3_H:    bad = addr_lo[0];
                F3_W:    bad = |addr_lo;
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads; purely combinational.
module mem_align
    import stage_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_value
);

    logic [7:0]  lbyte;
    logic [15:0] lhalf;

    // Only the size bits matter for lanes, so unsigned loads get proper enables too.
    always_comb begin
        st_wdata = st_data;
        st_be    = BE_WORD;
        case (st_funct3[1:0])
            2'b00: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = BE_BYTE0 << st_addr_lo;
            end
            2'b01: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = st_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            end
            default: begin
                st_wdata = st_data;
                st_be    = BE_WORD;
            end
        endcase
    end

    always_comb begin
        case (ld_addr_lo)
            2'd0:    lbyte = ld_rdata[7:0];
            2'd1:    lbyte = ld_rdata[15:8];
            2'd2:    lbyte = ld_rdata[23:16];
            default: lbyte = ld_rdata[31:24];
        endcase
        lhalf = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_value = {{24{lbyte[7]}}, lbyte};
            F3_H:    ld_value = {{16{lhalf[15]}}, lhalf};
            F3_BU:   ld_value = {24'b0, lbyte};
            F3_HU:   ld_value = {16'b0, lhalf};
            default: ld_value = ld_rdata;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: accepts EX results, runs the req/gnt/rvalid
// data-memory handshake and produces a registered write-back bundle.
module stage_mem
    import stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] aluout,
    input  logic [31:0] store_data,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        regwrite,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic        exc_access,
    output logic        exc_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    ld_funct3;
    logic [1:0]    ld_addr_lo;
    logic [4:0]    req_rd;
    logic          req_regwrite;
    logic [31:0]   st_wdata;
    logic [3:0]    st_be;
    logic [31:0]   ld_value;
    logic          accept;
    logic          illegal;
    logic          is_mem;

    assign accept  = in_valid && in_ready;
    assign is_mem  = memread || memwrite;
    assign illegal = access_illegal(memread, memwrite, funct3, aluout[1:0]);

    mem_align u_align (
        .st_funct3  (funct3),
        .st_addr_lo (aluout[1:0]),
        .st_data    (store_data),
        .st_wdata   (st_wdata),
        .st_be      (st_be),
        .ld_funct3  (ld_funct3),
        .ld_addr_lo (ld_addr_lo),
        .ld_rdata   (mem_rdata),
        .ld_value   (ld_value)
    );

    // Completion beats timeout; a load grant is not completion, so it can still time out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            in_ready     <= 1'b1;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            exc_access   <= 1'b0;
            exc_timeout  <= 1'b0;
            ld_funct3    <= '0;
            ld_addr_lo   <= '0;
            req_rd       <= '0;
            req_regwrite <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            exc_access  <= 1'b0;
            exc_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            wb_valid    <= 1'b1;
                            wb_data     <= aluout;
                            wb_rd       <= rd;
                            wb_regwrite <= regwrite;
                        end else if (illegal) begin
                            exc_access  <= 1'b1;
                            wb_valid    <= 1'b1;
                            wb_data     <= aluout;
                            wb_rd       <= rd;
                            wb_regwrite <= 1'b0;
                        end else begin
                            state        <= ST_REQ;
                            in_ready     <= 1'b0;
                            cnt          <= '0;
                            mem_req      <= 1'b1;
                            mem_we       <= memwrite;
                            mem_addr     <= {aluout[31:2], 2'b00};
                            mem_wdata    <= memwrite ? st_wdata : 32'b0;
                            mem_be       <= st_be;
                            ld_funct3    <= funct3;
                            ld_addr_lo   <= aluout[1:0];
                            req_rd       <= rd;
                            req_regwrite <= regwrite;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (state == ST_REQ && mem_gnt && mem_we) begin
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_rd       <= req_rd;
                        wb_regwrite <= 1'b0;
                        state       <= ST_IDLE;
                        in_ready    <= 1'b1;
                    end else if (state == ST_WAIT && mem_rvalid) begin
                        wb_valid    <= 1'b1;
                        wb_data     <= ld_value;
                        wb_rd       <= req_rd;
                        wb_regwrite <= req_regwrite;
                        state       <= ST_IDLE;
                        in_ready    <= 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        exc_timeout <= 1'b1;
                        wb_valid    <= 1'b1;
                        wb_rd       <= req_rd;
                        wb_regwrite <= 1'b0;
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        state       <= ST_IDLE;
                        in_ready    <= 1'b1;
                    end else if (state == ST_REQ && mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= ST_WAIT;
                        cnt     <= cnt + CW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: drives inputs and samples outputs on the
// falling edge, expected values worked out by hand from the stage behaviour.
module tb_stage_mem;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] aluout;
    logic [31:0] store_data;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        regwrite;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        exc_access;
    logic        exc_timeout;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    stage_mem #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluout      (aluout),
        .store_data  (store_data),
        .memread     (memread),
        .memwrite    (memwrite),
        .funct3      (funct3),
        .rd          (rd),
        .regwrite    (regwrite),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .exc_access  (exc_access),
        .exc_timeout (exc_timeout)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic rdEn, input logic wrEn,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [4:0] rdIdx,
                                 input logic rw);
        in_valid   = v;
        memread    = rdEn;
        memwrite   = wrEn;
        funct3     = f3;
        aluout     = addr;
        store_data = data;
        rd         = rdIdx;
        regwrite   = rw;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Accept a load, grant next cycle, return data the cycle after; ends in the wb_valid cycle.
    task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] expAddr, input logic [31:0] rdata,
                           input logic [4:0] rdIdx);
        applyStimulus(1'b1, 1'b1, 1'b0, f3, addr, 32'h0, rdIdx, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput({tag, " mem_addr"}, mem_addr, expAddr);
        checkOutput({tag, " mem_we"}, {31'b0, mem_we}, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        checkOutput({tag, " wait_no_wb"}, {31'b0, wb_valid}, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        tick();
        tick();
        checkOutput("rst mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rst wb_valid", {31'b0, wb_valid}, 32'h0);
        checkOutput("rst mem_addr", mem_addr, 32'h0);
        checkOutput("rst wb_data", wb_data, 32'h0);
        checkOutput("rst mem_be", {28'b0, mem_be}, 32'h0);
        rst_n = 1'b1;
        tick();
        checkOutput("rst in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("rst exc", {30'b0, exc_access, exc_timeout}, 32'h0);

        // Pass-through, then two back-to-back to show one per cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        tick();
        checkOutput("pt wb_valid", {31'b0, wb_valid}, 32'h1);
        checkOutput("pt wb_data", wb_data, 32'h0000_1234);
        checkOutput("pt wb_rd", {27'b0, wb_rd}, 32'd5);
        checkOutput("pt wb_regwrite", {31'b0, wb_regwrite}, 32'h1);
        checkOutput("pt mem_req", {31'b0, mem_req}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_00AA, 32'h0, 5'd6, 1'b1);
        tick();
        checkOutput("pt2 wb_data", wb_data, 32'h0000_00AA);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_00BB, 32'h0, 5'd7, 1'b0);
        tick();
        checkOutput("pt3 wb_data", wb_data, 32'h0000_00BB);
        checkOutput("pt3 wb_valid", {31'b0, wb_valid}, 32'h1);
        checkOutput("pt3 wb_regwrite", {31'b0, wb_regwrite}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        checkOutput("pt pulse", {31'b0, wb_valid}, 32'h0);

        // SB to byte lane 3.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd9, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("sb mem_req", {31'b0, mem_req}, 32'h1);
        checkOutput("sb mem_we", {31'b0, mem_we}, 32'h1);
        checkOutput("sb mem_addr", mem_addr, 32'h0000_0100);
        checkOutput("sb mem_be", {28'b0, mem_be}, 32'h8);
        checkOutput("sb mem_wdata", mem_wdata, 32'hDDDD_DDDD);
        checkOutput("sb in_ready", {31'b0, in_ready}, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checkOutput("sb wb_valid", {31'b0, wb_valid}, 32'h1);
        checkOutput("sb wb_regwrite", {31'b0, wb_regwrite}, 32'h0);
        checkOutput("sb mem_req drop", {31'b0, mem_req}, 32'h0);
        checkOutput("sb in_ready back", {31'b0, in_ready}, 32'h1);

        // SH upper half.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h1122_3344, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("sh mem_be", {28'b0, mem_be}, 32'hC);
        checkOutput("sh mem_wdata", mem_wdata, 32'h3344_3344);
        checkOutput("sh mem_addr", mem_addr, 32'h0000_0000);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checkOutput("sh wb_valid", {31'b0, wb_valid}, 32'h1);

        // SW.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'h1122_3344, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("sw mem_be", {28'b0, mem_be}, 32'hF);
        checkOutput("sw mem_wdata", mem_wdata, 32'h1122_3344);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;

        // Loads with lane extraction and extension.
        runLoad("lb", 3'b000, 32'h0000_0202, 32'h0000_0200, 32'h0080_0000, 5'd7);
        checkOutput("lb wb_valid", {31'b0, wb_valid}, 32'h1);
        checkOutput("lb wb_data", wb_data, 32'hFFFF_FF80);
        checkOutput("lb wb_rd", {27'b0, wb_rd}, 32'd7);
        checkOutput("lb wb_regwrite", {31'b0, wb_regwrite}, 32'h1);
        runLoad("lbu", 3'b100, 32'h0000_0202, 32'h0000_0200, 32'h0080_0000, 5'd8);
        checkOutput("lbu wb_data", wb_data, 32'h0000_0080);
        runLoad("lh", 3'b001, 32'h0000_0202, 32'h0000_0200, 32'h8000_1234, 5'd3);
        checkOutput("lh wb_data", wb_data, 32'hFFFF_8000);
        runLoad("lhu", 3'b101, 32'h0000_0200, 32'h0000_0200, 32'h8000_9234, 5'd4);
        checkOutput("lhu wb_data", wb_data, 32'h0000_9234);

        // Illegal accesses.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0301, 32'h0, 5'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("lh_mis exc_access", {31'b0, exc_access}, 32'h1);
        checkOutput("lh_mis wb_valid", {31'b0, wb_valid}, 32'h1);
        checkOutput("lh_mis wb_regwrite", {31'b0, wb_regwrite}, 32'h0);
        checkOutput("lh_mis mem_req", {31'b0, mem_req}, 32'h0);
        tick();
        checkOutput("lh_mis pulse", {31'b0, exc_access}, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 5'd2, 1'b1);
        tick();
        checkOutput("rdwr exc_access", {31'b0, exc_access}, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0, 5'd2, 1'b1);
        tick();
        checkOutput("lw_mis exc_access", {31'b0, exc_access}, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd2, 1'b1);
        tick();
        checkOutput("f3ld exc_access", {31'b0, exc_access}, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0, 5'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        checkOutput("f3st exc_access", {31'b0, exc_access}, 32'h1);
        checkOutput("f3st mem_req", {31'b0, mem_req}, 32'h0);

        // Grant withheld for three cycles, then LW completes.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd11, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall mem_req", {31'b0, mem_req}, 32'h1);
            checkOutput("stall mem_addr", mem_addr, 32'h0000_0400);
            checkOutput("stall in_ready", {31'b0, in_ready}, 32'h0);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("stall wb_data", wb_data, 32'hDEAD_BEEF);
        checkOutput("stall wb_rd", {27'b0, wb_rd}, 32'd11);

        // Late handshake signals in IDLE are ignored.
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        checkOutput("late wb_valid", {31'b0, wb_valid}, 32'h0);
        checkOutput("late mem_req", {31'b0, mem_req}, 32'h0);

        // Timeout: counter 0 in the first REQ cycle, equals TMO in cycle TMO+1.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'h1, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < TMO; i++) tick();
        checkOutput("tmo early", {31'b0, exc_timeout}, 32'h0);
        checkOutput("tmo still req", {31'b0, mem_req}, 32'h1);
        tick();
        checkOutput("tmo exc_timeout", {31'b0, exc_timeout}, 32'h1);
        checkOutput("tmo wb_valid", {31'b0, wb_valid}, 32'h1);
        checkOutput("tmo wb_regwrite", {31'b0, wb_regwrite}, 32'h0);
        checkOutput("tmo mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("tmo in_ready", {31'b0, in_ready}, 32'h1);
        tick();
        checkOutput("tmo pulse", {31'b0, exc_timeout}, 32'h0);

        // Reset during REQ.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0600, 32'h5, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("rstreq mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rstreq wb_valid", {31'b0, wb_valid}, 32'h0);
        checkOutput("rstreq mem_addr", mem_addr, 32'h0);

        // Reset during WAIT, with rvalid arriving around it.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd12, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        rst_n      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        rst_n = 1'b1;
        checkOutput("rstwait mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rstwait wb_valid", {31'b0, wb_valid}, 32'h0);
        checkOutput("rstwait in_ready", {31'b0, in_ready}, 32'h1);
        tick();
        mem_rvalid = 1'b0;
        checkOutput("rstwait no_wb", {31'b0, wb_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
